// File: rtl/bf16_fma_wb_master.sv
`default_nettype none
// ============================================================================
//  Module   : bf16_fma_wb_master
//  Purpose  : Wishbone initiator for the bfloat16 FMA responder. Takes one
//             (a,b,c) triple, writes A/B/C, waits a settle period, reads the
//             RESULT register and returns result/flags on a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module bf16_fma_wb_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          SETTLE_CYCLES  = 4,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [15:0] cmd_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [9:0]  rsp_flags,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WR_A   = 4'd1;
    localparam logic [3:0] S_GAP_AB = 4'd2;
    localparam logic [3:0] S_WR_B   = 4'd3;
    localparam logic [3:0] S_GAP_BC = 4'd4;
    localparam logic [3:0] S_WR_C   = 4'd5;
    localparam logic [3:0] S_SETTLE = 4'd6;
    localparam logic [3:0] S_RD_RES = 4'd7;
    localparam logic [3:0] S_RESP   = 4'd8;

    localparam logic [31:0] c_OFS_B      = 32'h0000_0004;
    localparam logic [31:0] c_OFS_C      = 32'h0000_0008;
    localparam logic [31:0] c_OFS_RES    = 32'h0000_000C;
    localparam logic [7:0]  c_SETTLE_END = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] c_TMO_END    = 16'(TIMEOUT_CYCLES - 1);

    logic [3:0]  r_state;
    logic        r_live;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [15:0] r_b;
    logic [15:0] r_c;
    logic [15:0] r_tmo;
    logic [7:0]  r_settle;
    logic [15:0] r_result;
    logic [9:0]  r_flags;
    logic        r_timeout;

    logic        w_beat;
    logic        w_unused;

    // Upper read-data bits carry nothing of interest for this master.
    assign w_unused = ^wbm_dat_i[31:26];

    // A bus beat is in flight in any of the write or read states.
    assign w_beat = (r_state == S_WR_A) || (r_state == S_WR_B) ||
                    (r_state == S_WR_C) || (r_state == S_RD_RES);

    assign cmd_ready   = r_live && (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign wbm_cyc_o   = w_beat;
    assign wbm_stb_o   = w_beat;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = 4'hF;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_result  = r_result;
    assign rsp_flags   = r_flags;
    assign rsp_timeout = r_timeout;

    // Transaction sequencer: address/data are loaded on entry to a beat and
    // held until it ends, so they stay stable for slow responders.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_live    <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= 32'h0;
            r_dat     <= 32'h0;
            r_b       <= 16'h0;
            r_c       <= 16'h0;
            r_tmo     <= 16'h0;
            r_settle  <= 8'h0;
            r_result  <= 16'h0;
            r_flags   <= 10'h0;
            r_timeout <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_live) begin
                        r_b       <= cmd_b;
                        r_c       <= cmd_c;
                        r_adr     <= BASE_ADDR;
                        r_we      <= 1'b1;
                        r_dat     <= {16'h0, cmd_a};
                        r_tmo     <= 16'h0;
                        r_timeout <= 1'b0;
                        r_state   <= S_WR_A;
                    end
                end
                S_WR_A, S_WR_B, S_WR_C, S_RD_RES: begin
                    // An ack arriving on the expiry cycle still wins.
                    if (wbm_ack_i) begin
                        if (r_state == S_WR_A) begin
                            r_state <= S_GAP_AB;
                        end else if (r_state == S_WR_B) begin
                            r_state <= S_GAP_BC;
                        end else if (r_state == S_WR_C) begin
                            r_settle <= 8'h0;
                            r_state  <= S_SETTLE;
                        end else begin
                            r_result <= wbm_dat_i[15:0];
                            r_flags  <= wbm_dat_i[25:16];
                            r_state  <= S_RESP;
                        end
                    end else if (r_tmo == c_TMO_END) begin
                        r_result  <= 16'h0;
                        r_flags   <= 10'h0;
                        r_timeout <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 16'h1;
                    end
                end
                S_GAP_AB: begin
                    r_adr   <= BASE_ADDR + c_OFS_B;
                    r_dat   <= {16'h0, r_b};
                    r_tmo   <= 16'h0;
                    r_state <= S_WR_B;
                end
                S_GAP_BC: begin
                    r_adr   <= BASE_ADDR + c_OFS_C;
                    r_dat   <= {16'h0, r_c};
                    r_tmo   <= 16'h0;
                    r_state <= S_WR_C;
                end
                S_SETTLE: begin
                    if (r_settle == c_SETTLE_END) begin
                        r_adr   <= BASE_ADDR + c_OFS_RES;
                        r_we    <= 1'b0;
                        r_dat   <= 32'h0;
                        r_tmo   <= 16'h0;
                        r_state <= S_RD_RES;
                    end else begin
                        r_settle <= r_settle + 8'h1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_timeout <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bf16_fma_wb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bf16_fma_wb_master
//  Purpose  : Self-checking bench for bf16_fma_wb_master with a behavioural
//             Wishbone responder and a transaction-level expectation model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bf16_fma_wb_master;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int SETTLE = 4;
    localparam int TMO    = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = 16'h0, cmd_b = 16'h0, cmd_c = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [9:0]  rsp_flags;
    logic        rsp_timeout;
    logic        busy;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;

    int          checks = 0;
    int          errors = 0;

    // responder model controls
    int          s_delay = 0;
    logic [31:0] s_block_adr = 32'hFFFF_FFFF;
    logic [31:0] s_rdata = 32'h0;
    int          s_cnt = 0;

    // monitor records
    beat_t       log_q[$];
    int          start_q[$];
    int          ack_q[$];
    int          len_q[$];
    int          unstable = 0;
    int          cyc_n = 0;
    int          cur_len = 0;
    logic        prev_cs = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_adr = 32'h0, prev_dat = 32'h0;

    always #5 clk = ~clk;

    bf16_fma_wb_master #(
        .BASE_ADDR(BASE), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
        .busy(busy),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
    );

    // Responder: acks after s_delay wait cycles, never acks s_block_adr.
    assign ack   = cyc && stb && (s_cnt >= s_delay) && (adr != s_block_adr);
    assign dat_i = s_rdata;

    always @(posedge clk) begin
        if (cyc && stb && !ack) s_cnt <= s_cnt + 1;
        else                    s_cnt <= 0;
    end

    // Bus monitor: beat log, beat start/ack cycle stamps, lengths, stability.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (cyc && stb) begin
            if (!prev_cs || prev_ack) begin
                start_q.push_back(cyc_n);
                cur_len <= 1;
            end else begin
                cur_len <= cur_len + 1;
                if (adr != prev_adr || dat_o != prev_dat || we != prev_we)
                    unstable <= unstable + 1;
            end
            if (ack) begin
                log_q.push_back({we, adr, (we ? dat_o : dat_i)});
                ack_q.push_back(cyc_n);
            end
        end else if (prev_cs) begin
            len_q.push_back(cur_len);
        end
        prev_cs  <= cyc && stb;
        prev_ack <= ack;
        prev_adr <= adr;
        prev_dat <= dat_o;
        prev_we  <= we;
    end

    // One full command/response exchange checked against the transaction model.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [31:0] rword, input int stall, input string nm);
        beat_t       exp_q[$];
        logic        exp_to;
        logic [15:0] er;
        logic [9:0]  ef;
        int          n_exp, n_starts, s0, a0, l0, u0, len0, lat, n;
        exp_to = 1'b0;
        exp_q.push_back({1'b1, BASE,           {16'h0, a}});
        exp_q.push_back({1'b1, BASE + 32'h4,   {16'h0, b}});
        exp_q.push_back({1'b1, BASE + 32'h8,   {16'h0, c}});
        exp_q.push_back({1'b0, BASE + 32'hC,   rword});
        n_exp = 4;
        for (int i = 0; i < 4; i++) begin
            if (!exp_to && exp_q[i].adr == s_block_adr) begin
                n_exp  = i;
                exp_to = 1'b1;
            end
        end
        n_starts = exp_to ? n_exp + 1 : n_exp;
        er = exp_to ? 16'h0 : rword[15:0];
        ef = exp_to ? 10'h0 : rword[25:16];
        s_rdata = rword;
        s0 = start_q.size(); a0 = ack_q.size(); l0 = log_q.size();
        u0 = unstable; len0 = len_q.size();

        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_c = c; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!cmd_ready) begin
            errors++; $display("FAIL %s accept: cmd_ready got 0 want 1", nm);
            cmd_valid = 1'b0; return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
        checks++;
        if (!rsp_valid) begin
            errors++; $display("FAIL %s rsp_wait: rsp_valid got 0 want 1", nm); return;
        end
        if (!exp_to) begin
            checks++;
            if (lat != 4 * (1 + s_delay) + 2 + SETTLE) begin
                errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, 4 * (1 + s_delay) + 2 + SETTLE);
            end
        end
        checks++;
        if (rsp_result !== er || rsp_flags !== ef || rsp_timeout !== exp_to) begin
            errors++; $display("FAIL %s response: got %h/%h/%b want %h/%h/%b", nm,
                               rsp_result, rsp_flags, rsp_timeout, er, ef, exp_to);
        end
        checks++;
        if (log_q.size() - l0 != n_exp) begin
            errors++; $display("FAIL %s beat_count: got %0d want %0d", nm, log_q.size() - l0, n_exp);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                checks++;
                if (log_q[l0 + i] !== exp_q[i]) begin
                    errors++; $display("FAIL %s beat%0d: got %h want %h", nm, i, log_q[l0 + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (unstable != u0) begin
            errors++; $display("FAIL %s stable: changes got %0d want 0", nm, unstable - u0);
        end
        checks++;
        if (start_q.size() - s0 != n_starts || ack_q.size() - a0 != n_exp) begin
            errors++; $display("FAIL %s starts: got %0d want %0d", nm, start_q.size() - s0, n_starts);
        end else begin
            for (int i = 0; i + 1 < n_starts; i++) begin
                checks++;
                if (start_q[s0 + i + 1] - ack_q[a0 + i] != ((i < 2) ? 2 : 1 + SETTLE)) begin
                    errors++; $display("FAIL %s gap%0d: got %0d want %0d", nm, i,
                                       start_q[s0 + i + 1] - ack_q[a0 + i], (i < 2) ? 2 : 1 + SETTLE);
                end
            end
        end
        // Hold the response back while offering a new command that must be ignored.
        cmd_a = 16'($urandom); cmd_valid = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if (!rsp_valid || rsp_result !== er || rsp_flags !== ef || rsp_timeout !== exp_to ||
                cmd_ready || start_q.size() - s0 != n_starts) begin
                errors++; $display("FAIL %s hold%0d: got v=%b r=%h f=%h t=%b rdy=%b want v=1 r=%h f=%h t=%b rdy=0",
                                   nm, i, rsp_valid, rsp_result, rsp_flags, rsp_timeout, cmd_ready, er, ef, exp_to);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid || rsp_timeout || !cmd_ready) begin
            errors++; $display("FAIL %s handshake: got v=%b t=%b rdy=%b want 0/0/1", nm, rsp_valid, rsp_timeout, cmd_ready);
        end
        if (exp_to) begin
            checks++;
            if (len_q.size() == len0 || len_q[len_q.size() - 1] != TMO) begin
                errors++; $display("FAIL %s timeout_len: got %0d want %0d", nm,
                                   (len_q.size() == len0) ? -1 : len_q[len_q.size() - 1], TMO);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cyc || stb || we || sel !== 4'hF || adr !== 32'h0 || dat_o !== 32'h0 ||
            rsp_valid || rsp_result !== 16'h0 || rsp_flags !== 10'h0 || rsp_timeout || busy || cmd_ready) begin
            errors++; $display("FAIL reset_state: got cyc=%b stb=%b we=%b sel=%h adr=%h v=%b busy=%b rdy=%b want 0/0/0/f/0/0/0/0",
                               cyc, stb, we, sel, adr, rsp_valid, busy, cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (!cmd_ready || busy) begin
            errors++; $display("FAIL reset_ready: got rdy=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        s_delay = 0;
        run_txn(16'h3F80, 16'h4000, 16'h4040, 32'h0000_40A0, 0, "basic");
    endtask

    task automatic test_flags();
        s_delay = 0;
        run_txn(16'h1234, 16'h5678, 16'h9ABC, 32'h03FF_7F80, 0, "flags");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            s_delay = int'($urandom_range(0, 3));
            run_txn(16'($urandom), 16'($urandom), 16'($urandom), $urandom, int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_slow_ack();
        s_delay = 5;
        run_txn(16'hC0A0, 16'h3E00, 16'h0001, 32'hFC00_1234, 0, "slow_ack");
    endtask

    task automatic test_ack_at_expiry();
        s_delay = TMO - 1;
        run_txn(16'h0F0F, 16'hF0F0, 16'h5555, 32'h0155_AAAA, 0, "ack_expiry");
    endtask

    task automatic test_timeout();
        s_delay = 0;
        run_txn(16'h1111, 16'h2222, 16'h3333, 32'h0123_4567, 1, "seed");
        s_block_adr = BASE + 32'h4;
        run_txn(16'h4444, 16'h5555, 16'h6666, 32'h0123_4567, 0, "timeout");
        s_block_adr = 32'hFFFF_FFFF;
        run_txn(16'h7777, 16'h8888, 16'h9999, 32'h0321_0BEE, 0, "after_timeout");
    endtask

    task automatic test_stall();
        s_delay = 1;
        run_txn(16'hBF80, 16'h4000, 16'h3F80, 32'h0000_BF80, 10, "stall");
    endtask

    task automatic test_reset_mid();
        int n;
        s_delay = 0;
        s_block_adr = BASE + 32'h8;
        @(negedge clk);
        cmd_a = 16'hAAAA; cmd_b = 16'hBBBB; cmd_c = 16'hCCCC; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(cyc && adr == BASE + 32'h8) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!(cyc && adr == BASE + 32'h8)) begin
            errors++; $display("FAIL reset_mid_reach: got cyc=%b adr=%h want 1/%h", cyc, adr, BASE + 32'h8);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cyc || stb || busy || rsp_valid) begin
            errors++; $display("FAIL reset_mid_drop: got cyc=%b stb=%b busy=%b v=%b want 0/0/0/0", cyc, stb, busy, rsp_valid);
        end
        rst = 1'b0;
        s_block_adr = 32'hFFFF_FFFF;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || cyc) n++;
        end
        checks++;
        if (n != 0 || !cmd_ready) begin
            errors++; $display("FAIL reset_mid_quiet: got active=%0d rdy=%b want 0/1", n, cmd_ready);
        end
        run_txn(16'h3F80, 16'h3F80, 16'h0000, 32'h0000_3F80, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_random();
        test_slow_ack();
        test_ack_at_expiry();
        test_timeout();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
